// File: rtl/chi_tx_link_arbiter.sv
// CHI TX link arbiter: round-robin flit arbitration gated by L-credits, plus the TX link-activation FSM.
// Optional perf counters (flit_cnt, stall_cnt) are enabled by defining CHI_TXARB_PERF_CNT_EN.
module chi_tx_link_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int FLIT_W  = 128,
    parameter int MAX_CRD = 15,
    parameter int CRD_W   = $clog2(MAX_CRD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      link_en,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*FLIT_W-1:0] src_flit,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      TX_FLITPEND,
    output logic                      TX_FLITV,
    output logic [FLIT_W-1:0]         TX_FLIT,
    input  logic                      TX_LCRDV,
    output logic                      TX_LINKACTIVEREQ,
    input  logic                      TX_LINKACTIVEACK,
    output logic [CRD_W-1:0]          credit_cnt,
    output logic [1:0]                link_state,
    output logic                      crd_ovf
`ifdef CHI_TXARB_PERF_CNT_EN
    ,
    output logic [31:0]               flit_cnt,
    output logic [31:0]               stall_cnt
`endif
);

    // state      | meaning
    // STOP       | link down, credits ignored
    // ACTIVATE   | REQ high, waiting for ACK
    // RUN        | link up, source flits granted against credits
    // DEACTIVATE | REQ low, returning held credits as link flits
    typedef enum logic [1:0] {
        ST_STOP       = 2'd0,
        ST_ACTIVATE   = 2'd1,
        ST_RUN        = 2'd2,
        ST_DEACTIVATE = 2'd3
    } state_t;

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [CRD_W-1:0]   r_crd;
    logic               r_req;
    logic               r_flitv;
    logic               r_ovf;
    logic [FLIT_W-1:0]  r_flit;

    logic               w_run;
    logic               w_deact;
    logic               w_any_valid;
    logic               w_has_crd;
    logic               w_grant;
    logic               w_send;
    logic               w_crd_in;
    logic               w_crd_max;
    int                 w_win;
    int                 w_best;
    int                 w_dist;
    logic [FLIT_W-1:0]  w_sel_flit;

    assign w_run       = (r_state == ST_RUN);
    assign w_deact     = (r_state == ST_DEACTIVATE);
    assign w_any_valid = |src_valid;
    assign w_has_crd   = (r_crd != '0);
    assign w_crd_max   = (r_crd == CRD_W'(MAX_CRD));
    assign w_grant     = w_run && w_has_crd && w_any_valid;
    assign w_send      = w_grant || (w_deact && w_has_crd);
    assign w_crd_in    = TX_LCRDV && (r_state != ST_STOP);

    // r_ptr is the highest-priority source; pick the valid one closest to it going upward.
    always_comb begin
        w_win  = 0;
        w_best = NUM_SRC;
        w_dist = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + NUM_SRC - int'(r_ptr));
            if (src_valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = i;
            end
        end
    end

    always_comb begin
        w_sel_flit = '0;
        src_ready  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i == w_win) w_sel_flit = src_flit[i*FLIT_W +: FLIT_W];
            src_ready[i] = w_grant && (i == w_win);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_STOP;
            r_req   <= 1'b0;
            r_ptr   <= '0;
            r_crd   <= '0;
            r_ovf   <= 1'b0;
            r_flitv <= 1'b0;
            r_flit  <= '0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    if (link_en) begin
                        r_state <= ST_ACTIVATE;
                        r_req   <= 1'b1;
                    end
                end
                ST_ACTIVATE: begin
                    if (TX_LINKACTIVEACK) begin
                        r_state <= link_en ? ST_RUN : ST_DEACTIVATE;
                        r_req   <= link_en;
                    end
                end
                ST_RUN: begin
                    if (!link_en) begin
                        r_state <= ST_DEACTIVATE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    if (!w_has_crd && !TX_LINKACTIVEACK) r_state <= ST_STOP;
                end
            endcase

            if (w_crd_in && w_crd_max) r_ovf <= 1'b1;
            if (w_crd_in && !w_send) begin
                if (!w_crd_max) r_crd <= r_crd + 1'b1;
            end else if (!w_crd_in && w_send) begin
                r_crd <= r_crd - 1'b1;
            end

            if (w_grant) r_ptr <= (w_win == NUM_SRC - 1) ? '0 : PTR_W'(w_win + 1);

            // Link flits carry an all-zero payload; TX_FLIT holds when nothing is sent.
            r_flitv <= w_send;
            if (w_send) r_flit <= w_grant ? w_sel_flit : '0;
        end
    end

    assign TX_FLITPEND      = (w_run && w_any_valid) || (w_deact && w_has_crd);
    assign TX_FLITV         = r_flitv;
    assign TX_FLIT          = r_flit;
    assign TX_LINKACTIVEREQ = r_req;
    assign credit_cnt       = r_crd;
    assign link_state       = r_state;
    assign crd_ovf          = r_ovf;

`ifdef CHI_TXARB_PERF_CNT_EN
    logic        r_flit_src;
    logic [31:0] r_flit_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flit_src  <= 1'b0;
            r_flit_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_flit_src <= w_grant;
            if (r_flitv && r_flit_src) r_flit_cnt <= r_flit_cnt + 32'd1;
            if (w_run && w_any_valid && !w_has_crd) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign flit_cnt  = r_flit_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_chi_tx_link_arbiter.sv
// Self-checking bench for chi_tx_link_arbiter: behavioural model with a latency-1 flit scoreboard,
// a round-robin vector table and directed bring-up / stall / overflow / reset / teardown sequences.
module tb_chi_tx_link_arbiter;
    localparam int N  = 4;
    localparam int W  = 128;
    localparam int MC = 15;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst, link_en, lcrdv, ack;
    logic [N-1:0]   v, ready;
    logic [N*W-1:0] flit;
    logic           pend, fv, req, ovf;
    logic [W-1:0]   txf;
    logic [CW-1:0]  crd;
    logic [1:0]     ls;

    always #5 clk = ~clk;

    chi_tx_link_arbiter #(.NUM_SRC(N), .FLIT_W(W), .MAX_CRD(MC)) dut (
        .clk(clk), .rst(rst), .link_en(link_en),
        .src_valid(v), .src_flit(flit), .src_ready(ready),
        .TX_FLITPEND(pend), .TX_FLITV(fv), .TX_FLIT(txf),
        .TX_LCRDV(lcrdv), .TX_LINKACTIVEREQ(req), .TX_LINKACTIVEACK(ack),
        .credit_cnt(crd), .link_state(ls), .crd_ovf(ovf)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         v;
        logic [W-1:0] f;
    } sb_t;
    sb_t sbq[$];

    int           m_st, m_crd, m_ptr, seq;
    bit           m_ovf;
    logic [W-1:0] m_last;
    logic [N-1:0] rdy, dummy;

    typedef struct {
        logic [N-1:0] v;
        bit           lc;
        logic [N-1:0] er;
    } vec_t;
    vec_t vt[15];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_flit(input int s);
        flit[s*W +: W] = {$urandom, $urandom, $urandom, 24'(seq), 8'(s)};
        seq++;
    endtask

    task automatic model_reset();
        sb_t e;
        m_st = 0; m_crd = 0; m_ptr = 0; m_ovf = 0; m_last = '0;
        sbq.delete();
        e.v = 1'b0; e.f = '0;
        sbq.push_back(e);
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model, return 1 after the rising edge.
    task automatic cyc(input bit r, input bit en, input bit lc, input bit ak,
                       input logic [N-1:0] vv, output logic [N-1:0] rdy_s);
        sb_t          e;
        bit           grant, send, cin;
        int           win, nst;
        logic [N-1:0] er;
        rst = r; link_en = en; lcrdv = lc; ack = ak; v = vv;
        @(negedge clk);
        rdy_s = ready;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got empty queue expected one entry");
        end else begin
            e = sbq.pop_front();
            chk("flitv", fv, e.v);
            if (e.v) m_last = e.f;
            chk("flit", txf, m_last);
        end
        chk("state", ls, m_st);
        chk("crd", crd, m_crd);
        chk("req", req, (m_st == 1 || m_st == 2));
        chk("ovf", ovf, m_ovf);
        grant = (m_st == 2) && (m_crd > 0) && (vv != 0);
        win = 0;
        for (int k = N - 1; k >= 0; k--)
            if (vv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        send = grant || (m_st == 3 && m_crd > 0);
        er = '0;
        if (grant) er[win] = 1'b1;
        if (r) begin
            model_reset();
        end else begin
            chk("ready", ready, er);
            chk("pend", pend, (m_st == 2 && vv != 0) || (m_st == 3 && m_crd > 0));
            e.v = send;
            e.f = grant ? flit[win*W +: W] : '0;
            sbq.push_back(e);
            nst = m_st;
            case (m_st)
                0: if (en) nst = 1;
                1: if (ak) nst = en ? 2 : 3;
                2: if (!en) nst = 3;
                default: if (m_crd == 0 && !ak) nst = 0;
            endcase
            cin = lc && (m_st != 0);
            if (cin && m_crd == MC) m_ovf = 1;
            if (cin && !send) m_crd = (m_crd == MC) ? MC : m_crd + 1;
            else if (!cin && send) m_crd = m_crd - 1;
            if (grant) m_ptr = (win + 1) % N;
            m_st = nst;
        end
        @(posedge clk);
        #1;
        if (grant && !r) new_flit(win);
    endtask

    initial begin
        seq = 0;
        for (int s = 0; s < N; s++) new_flit(s);
        rst = 1'b1; link_en = 1'b0; lcrdv = 1'b0; ack = 1'b0; v = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_state", ls, 0);
        chk("rst_flitv", fv, 0);
        chk("rst_flit", txf, 0);
        chk("rst_crd", crd, 0);
        chk("rst_req", req, 0);

        // bring-up: ACK two cycles after REQ, three credits during ACTIVATE
        cyc(0, 1, 0, 0, '0, dummy);
        chk("up_state_act", ls, 1);
        chk("up_req", req, 1);
        cyc(0, 1, 1, 0, '0, dummy);
        cyc(0, 1, 1, 0, '0, dummy);
        cyc(0, 1, 1, 1, '0, dummy);
        chk("up_state_run", ls, 2);
        chk("up_crd3", crd, 3);
        repeat (12) cyc(0, 1, 1, 1, '0, dummy);
        chk("crd_full", crd, 15);

        // round-robin table
        for (int i = 0; i < 8; i++) begin
            vt[i].v = 4'b1111; vt[i].lc = 0; vt[i].er = 4'b0001 << (i % 4);
        end
        vt[8]  = '{4'b0101, 0, 4'b0001};
        vt[9]  = '{4'b0101, 0, 4'b0100};
        vt[10] = '{4'b0101, 0, 4'b0001};
        vt[11] = '{4'b1010, 0, 4'b0010};
        vt[12] = '{4'b1010, 0, 4'b1000};
        vt[13] = '{4'b0000, 0, 4'b0000};
        vt[14] = '{4'b0001, 1, 4'b0001};
        for (int i = 0; i < 15; i++) begin
            cyc(0, 1, vt[i].lc, 1, vt[i].v, rdy);
            chk($sformatf("rr_vec%0d", i), rdy, vt[i].er);
        end
        chk("simul_crd", crd, 2);

        // credit stall
        cyc(0, 1, 0, 1, 4'b0001, dummy);
        chk("stall_crd1", crd, 1);
        cyc(0, 1, 0, 1, 4'b0011, rdy);
        chk("stall_grant", rdy, 4'b0010);
        chk("stall_crd0", crd, 0);
        cyc(0, 1, 0, 1, 4'b0011, rdy);
        chk("stall_rdy0", rdy, 0);
        cyc(0, 1, 1, 1, 4'b0011, rdy);
        chk("stall_rdy_crdin", rdy, 0);
        cyc(0, 1, 0, 1, 4'b0011, rdy);
        chk("stall_resume", rdy, 4'b0001);
        cyc(0, 1, 0, 1, 4'b0000, dummy);
        chk("stall_crd_end", crd, 0);

        // overflow
        repeat (15) cyc(0, 1, 1, 1, '0, dummy);
        chk("ovf_crd15", crd, 15);
        chk("ovf_clear", ovf, 0);
        cyc(0, 1, 1, 1, '0, dummy);
        chk("ovf_crd_sat", crd, 15);
        chk("ovf_set", ovf, 1);

        // reset in the middle of back-to-back grants
        repeat (3) cyc(0, 1, 0, 1, 4'b1111, dummy);
        cyc(1, 1, 0, 1, 4'b1111, dummy);
        chk("mid_rst_flitv", fv, 0);
        chk("mid_rst_crd", crd, 0);
        chk("mid_rst_state", ls, 0);
        chk("mid_rst_req", req, 0);
        chk("mid_rst_ovf", ovf, 0);

        // second bring-up with four credits, pointer back at source 0
        cyc(0, 1, 0, 0, '0, dummy);
        cyc(0, 1, 1, 0, '0, dummy);
        cyc(0, 1, 1, 1, '0, dummy);
        cyc(0, 1, 1, 1, '0, dummy);
        cyc(0, 1, 1, 1, '0, dummy);
        chk("up2_crd4", crd, 4);
        cyc(0, 1, 1, 1, 4'b1111, rdy);
        chk("ptr_after_rst", rdy, 4'b0001);
        chk("up2_crd_hold", crd, 4);

        // teardown: four link flits, then STOP once ACK drops
        cyc(0, 0, 0, 1, '0, dummy);
        chk("td_state", ls, 3);
        chk("td_req", req, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 4'b1111, rdy);
            chk("td_no_grant", rdy, 0);
        end
        chk("td_crd0", crd, 0);
        cyc(0, 0, 0, 1, '0, dummy);
        chk("td_wait_ack", ls, 3);
        cyc(0, 0, 0, 0, '0, dummy);
        chk("td_stop", ls, 0);

        // ACK arriving after link_en dropped goes to DEACTIVATE
        cyc(0, 1, 0, 0, '0, dummy);
        cyc(0, 0, 0, 0, '0, dummy);
        chk("abort_hold_act", ls, 1);
        chk("abort_hold_req", req, 1);
        cyc(0, 0, 0, 1, '0, dummy);
        chk("abort_deact", ls, 3);
        cyc(0, 0, 0, 0, '0, dummy);
        chk("abort_stop", ls, 0);
        repeat (2) cyc(0, 0, 0, 0, '0, dummy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
